// File: rtl/bram_window_streamer_pkg.sv
// Shared definitions for the 3x3 window streamer and the conv engine that consumes its windows.
package bram_window_streamer_pkg;

  localparam int unsigned WIN_K    = 3;
  localparam int unsigned WIN_TAPS = WIN_K * WIN_K;

  // Slot index of tap (r, c) inside a packed window; r=0 is the top row, c=0 the left column.
  function automatic int unsigned win_slot(input int unsigned r, input int unsigned c);
    return r * WIN_K + c;
  endfunction

endpackage

// File: rtl/bram_window_streamer_line_buffer.sv
// One image row of pixels; the read at a column sees the old value while the same column is rewritten.
module bram_window_streamer_line_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rd_data_c = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/bram_window_streamer.sv
// Reads an IMG_H x IMG_W image from BRAM in raster order and streams every valid 3x3 window
// to the convolution stage over a valid/ready handshake.
module bram_window_streamer
  import bram_window_streamer_pkg::*;
#(
  parameter int unsigned IMG_W      = 16,
  parameter int unsigned IMG_H      = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           bram_rd_en,
  output logic [ADDR_WIDTH-1:0]          bram_addr,
  input  logic [DATA_WIDTH-1:0]          bram_rd_data,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [WIN_TAPS*DATA_WIDTH-1:0] win_data,
  output logic [7:0]                     win_row,
  output logic [7:0]                     win_col
);

  localparam int unsigned LB_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                  state, state_next;
  logic [7:0]              x, y, x_next, y_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    load, advance, last_pix;
  logic [DATA_WIDTH-1:0]   lb0_rd, lb1_rd;

  // lb0 holds row y-1, lb1 holds row y-2 at the current column.
  bram_window_streamer_line_buffer #(
    .DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH), .AW(LB_AW)
  ) u_lb0 (
    .clk(clk), .wr_en(load), .addr(LB_AW'(x)), .wr_data(bram_rd_data), .rd_data_c(lb0_rd)
  );

  bram_window_streamer_line_buffer #(
    .DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH), .AW(LB_AW)
  ) u_lb1 (
    .clk(clk), .wr_en(load), .addr(LB_AW'(x)), .wr_data(lb0_rd), .rd_data_c(lb1_rd)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      bram_addr  <= '0;
      bram_rd_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else begin
      state      <= state_next;
      x          <= x_next;
      y          <= y_next;
      bram_addr  <= addr_next;
      bram_rd_en <= (state_next == S_FETCH);
      busy       <= (state_next == S_FETCH) || (state_next == S_LOAD) || (state_next == S_EMIT);
      done       <= (state_next == S_DONE);
      win_valid  <= (state_next == S_EMIT);
      if (load && (state_next == S_EMIT)) begin
        win_row <= y - 8'd2;
        win_col <= x - 8'd2;
      end
    end
  end

  // Window shifts left on every pixel load; the new right column is {row y-2, row y-1, row y}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_data <= '0;
    end else if (load) begin
      for (int unsigned r = 0; r < WIN_K; r++) begin
        win_data[win_slot(r, 0)*DATA_WIDTH +: DATA_WIDTH] <= win_data[win_slot(r, 1)*DATA_WIDTH +: DATA_WIDTH];
        win_data[win_slot(r, 1)*DATA_WIDTH +: DATA_WIDTH] <= win_data[win_slot(r, 2)*DATA_WIDTH +: DATA_WIDTH];
      end
      win_data[win_slot(0, 2)*DATA_WIDTH +: DATA_WIDTH] <= lb1_rd;
      win_data[win_slot(1, 2)*DATA_WIDTH +: DATA_WIDTH] <= lb0_rd;
      win_data[win_slot(2, 2)*DATA_WIDTH +: DATA_WIDTH] <= bram_rd_data;
    end
  end

  // Next-state and counter advance; windows are only emitted once a full 3x3 neighbourhood exists.
  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    addr_next  = bram_addr;
    load       = 1'b0;
    advance    = 1'b0;
    last_pix   = (x == 8'(IMG_W - 1)) && (y == 8'(IMG_H - 1));

    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          x_next     = '0;
          y_next     = '0;
          addr_next  = ADDR_WIDTH'(BASE_ADDR);
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        load = 1'b1;
        if ((y >= 8'd2) && (x >= 8'd2)) state_next = S_EMIT;
        else                            advance    = 1'b1;
      end
      S_EMIT:  advance    = win_ready;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (advance) begin
      if (last_pix) begin
        state_next = S_DONE;
      end else begin
        state_next = S_FETCH;
        addr_next  = bram_addr + ADDR_WIDTH'(1);
        if (x == 8'(IMG_W - 1)) begin
          x_next = '0;
          y_next = y + 8'd1;
        end else begin
          x_next = x + 8'd1;
        end
      end
    end
  end

endmodule
